// File: rtl/note_tracker.sv
// Frequency-to-note classifier with table scan and debounced display.
// Emits ASCII letter/octave digit and a one-cycle change strobe.
module note_tracker #(
   parameter int FREQ_W     = 16,
   parameter int MIN_OCTAVE = 2,
   parameter int NUM_OCT    = 4,
   parameter int STABLE_N   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freq_valid,
   output logic              freq_ready,
   input  logic [FREQ_W-1:0] frequency,
   output logic [7:0]        letter,
   output logic [7:0]        number,
   output logic              note_valid,
   output logic              note_changed
);

   localparam int BW = FREQ_W + 8;
   localparam int CW = $clog2(STABLE_N + 1);
   localparam int LS = (MIN_OCTAVE > 2) ? MIN_OCTAVE - 3 : 0;
   localparam logic [BW-1:0] LOW =
      (MIN_OCTAVE == 2) ? BW'(62) : (BW'(127) << LS) + BW'(1);
   localparam logic [BW-1:0] HIGH =
      BW'(127) << (MIN_OCTAVE - 2 + NUM_OCT - 1);

   typedef enum logic [1:0] {IDLE, RANGE, SCAN, COMMIT} state_t;

   state_t            state, nstate;
   logic [FREQ_W-1:0] f_q;
   logic [2:0]        ni, ok;
   logic              cand_none, last_none, disp_none;
   logic [2:0]        cand_i, cand_k;
   logic [2:0]        last_i, last_k;
   logic [2:0]        disp_i, disp_k;
   logic [CW-1:0]     run_cnt, run_nx;
   logic [BW-1:0]     f_ext, bound;
   logic [3:0]        sh;
   logic              in_range, hit;
   logic              same_last, same_disp, upd;

   function automatic logic [BW-1:0] base(input logic [2:0] i);
      case (i)
         3'd0:    base = BW'(69);
         3'd1:    base = BW'(78);
         3'd2:    base = BW'(85);
         3'd3:    base = BW'(93);
         3'd4:    base = BW'(104);
         3'd5:    base = BW'(117);
         default: base = BW'(127);
      endcase
   endfunction

   function automatic logic [7:0] ascii(input logic [2:0] i);
      case (i)
         3'd0:    ascii = 8'h43;
         3'd1:    ascii = 8'h44;
         3'd2:    ascii = 8'h45;
         3'd3:    ascii = 8'h46;
         3'd4:    ascii = 8'h47;
         3'd5:    ascii = 8'h41;
         default: ascii = 8'h42;
      endcase
   endfunction

   // Range test, current scan bound and debounce decisions
   always_comb begin
      f_ext     = BW'(f_q);
      sh        = 4'(MIN_OCTAVE - 2) + {1'b0, ok};
      bound     = base(ni) << sh;
      in_range  = (f_ext >= LOW) && (f_ext <= HIGH);
      hit       = (f_ext <= bound);
      same_last = (cand_none == last_none) &&
                  (cand_none || (cand_i == last_i && cand_k == last_k));
      same_disp = (cand_none == disp_none) &&
                  (cand_none || (cand_i == disp_i && cand_k == disp_k));
      if (!same_last)
         run_nx = CW'(1);
      else if (run_cnt == CW'(STABLE_N))
         run_nx = run_cnt;
      else
         run_nx = run_cnt + CW'(1);
      upd = (run_nx == CW'(STABLE_N)) && !same_disp;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // Next-state logic
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:   if (freq_valid) nstate = RANGE;
         RANGE:  nstate = in_range ? SCAN : COMMIT;
         SCAN:   if (hit) nstate = COMMIT;
         COMMIT: nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Handshake output
   always_comb begin
      freq_ready = (state == IDLE);
   end

   // Sample latch, scan counters, debounce and display registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_q          <= '0;
         ni           <= '0;
         ok           <= '0;
         cand_none    <= 1'b1;
         cand_i       <= '0;
         cand_k       <= '0;
         last_none    <= 1'b1;
         last_i       <= '0;
         last_k       <= '0;
         disp_none    <= 1'b1;
         disp_i       <= '0;
         disp_k       <= '0;
         run_cnt      <= '0;
         letter       <= 8'h20;
         number       <= 8'h20;
         note_valid   <= 1'b0;
         note_changed <= 1'b0;
      end else begin
         note_changed <= 1'b0;
         unique case (state)
            IDLE: if (freq_valid) f_q <= frequency;
            RANGE: begin
               ni <= '0;
               ok <= '0;
               if (!in_range) cand_none <= 1'b1;
            end
            SCAN: begin
               if (hit) begin
                  cand_none <= 1'b0;
                  cand_i    <= ni;
                  cand_k    <= ok;
               end else if (ni == 3'd6) begin
                  ni <= '0;
                  ok <= ok + 3'd1;
               end else begin
                  ni <= ni + 3'd1;
               end
            end
            COMMIT: begin
               last_none <= cand_none;
               last_i    <= cand_i;
               last_k    <= cand_k;
               run_cnt   <= run_nx;
               if (upd) begin
                  disp_none    <= cand_none;
                  disp_i       <= cand_i;
                  disp_k       <= cand_k;
                  note_changed <= 1'b1;
                  note_valid   <= !cand_none;
                  letter       <= cand_none ? 8'h20 : ascii(cand_i);
                  number       <= cand_none ? 8'h20 :
                     8'h30 + 8'(MIN_OCTAVE) + {5'b0, cand_k};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_note_tracker.sv
// Bench for note_tracker: fixed vectors, corner sequences and random
// samples against a note/debounce reference model.
module tb_note_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [15:0] freq;
   logic        sel;

   logic        r0, v0, c0, r1, v1, c1;
   logic [7:0]  l0, n0, l1, n1;
   logic        va0, va1;

   logic        cur_ready, cur_v, cur_chg;
   logic [7:0]  cur_l, cur_n;

   int nchk = 0;
   int nerr = 0;

   int p_min [2] = '{2, 3};
   int p_num [2] = '{4, 2};
   int p_stab[2] = '{3, 1};
   int m_last[2];
   int m_run [2];
   int m_disp[2];

   byte unsigned lt[7] = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h41, 8'h42};

   typedef struct {
      int f;
      int reps;
      int l;
      int n;
      int v;
   } vec_t;

   vec_t t2[6];
   vec_t t6[4];

   always #5 clk = ~clk;

   assign va0 = valid & ~sel;
   assign va1 = valid & sel;

   assign cur_ready = sel ? r1 : r0;
   assign cur_v     = sel ? v1 : v0;
   assign cur_chg   = sel ? c1 : c0;
   assign cur_l     = sel ? l1 : l0;
   assign cur_n     = sel ? n1 : n0;

   note_tracker u0 (
      .clk(clk), .reset(reset), .freq_valid(va0), .freq_ready(r0),
      .frequency(freq), .letter(l0), .number(n0),
      .note_valid(v0), .note_changed(c0)
   );

   note_tracker #(.FREQ_W(16), .MIN_OCTAVE(3), .NUM_OCT(2), .STABLE_N(1)) u1 (
      .clk(clk), .reset(reset), .freq_valid(va1), .freq_ready(r1),
      .frequency(freq), .letter(l1), .number(n1),
      .note_valid(v1), .note_changed(c1)
   );

   task automatic check(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   function automatic int ref_note(int f, int mo, int no);
      int u[7] = '{69, 78, 85, 93, 104, 117, 127};
      int low, high;
      low  = (mo == 2) ? 62 : (127 << (mo - 3)) + 1;
      high = 127 << (mo - 2 + no - 1);
      if (f < low || f > high) return -1;
      for (int k = 0; k < no; k++)
         for (int i = 0; i < 7; i++)
            if (f <= (u[i] << (mo - 2 + k))) return 7 * k + i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_last[s] = -1;
         m_run[s]  = 0;
         m_disp[s] = -1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send(int f, bit hold);
      int s, c, lat, ep, d, wn, done, pn, pat;
      s  = sel ? 1 : 0;
      wn = 0;
      @(negedge clk);
      while (!cur_ready && wn < 100) begin
         @(negedge clk);
         wn++;
      end
      check("ready_wait", int'(wn < 100), 1);
      freq  = 16'(f);
      valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) freq = 16'($urandom_range(0, 65535));
      else      valid = 1'b0;
      done = 0;
      pn   = 0;
      pat  = 0;
      for (int n = 1; n < 80 && done == 0; n++) begin
         @(negedge clk);
         if (cur_chg) begin
            pn++;
            pat = n;
         end
         if (cur_ready) done = n;
      end
      valid = 1'b0;
      c   = ref_note(f, p_min[s], p_num[s]);
      lat = (c < 0) ? 3 : 4 + c;
      if (c == m_last[s]) begin
         if (m_run[s] < p_stab[s]) m_run[s]++;
      end else begin
         m_last[s] = c;
         m_run[s]  = 1;
      end
      ep = (m_run[s] == p_stab[s] && c != m_disp[s]) ? 1 : 0;
      if (ep == 1) m_disp[s] = c;
      d = m_disp[s];
      check("latency", done, lat);
      check("pulses", pn, ep);
      check("pulse_cycle", pat, ep == 1 ? lat : 0);
      check("letter", int'(cur_l), d < 0 ? 32 : int'(lt[d % 7]));
      check("number", int'(cur_n), d < 0 ? 32 : 48 + p_min[s] + d / 7);
      check("note_valid", int'(cur_v), d < 0 ? 0 : 1);
   endtask

   task automatic check_disp(string name, int l, int n, int v);
      check({name, "_letter"}, int'(cur_l), l);
      check({name, "_number"}, int'(cur_n), n);
      check({name, "_valid"}, int'(cur_v), v);
   endtask

   initial begin
      t2[0] = '{61,   3, 8'h20, 8'h20, 0};
      t2[1] = '{62,   3, 8'h43, 8'h32, 1};
      t2[2] = '{69,   3, 8'h43, 8'h32, 1};
      t2[3] = '{70,   3, 8'h44, 8'h32, 1};
      t2[4] = '{1016, 3, 8'h42, 8'h35, 1};
      t2[5] = '{1017, 3, 8'h20, 8'h20, 0};
      t6[0] = '{127,  1, 8'h20, 8'h20, 0};
      t6[1] = '{128,  1, 8'h43, 8'h33, 1};
      t6[2] = '{508,  1, 8'h42, 8'h34, 1};
      t6[3] = '{509,  1, 8'h20, 8'h20, 0};

      sel   = 1'b0;
      reset = 1'b1;
      valid = 1'b0;
      freq  = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_disp("reset", 8'h20, 8'h20, 0);
      check("reset_chg", int'(c0), 0);
      check("reset_ready", int'(r0), 1);
      reset = 1'b0;

      // A4 after three samples
      for (int i = 0; i < 3; i++) begin
         send(440, 0);
         if (i < 2) check_disp("a4_early", 8'h20, 8'h20, 0);
      end
      check_disp("a4", 8'h41, 8'h34, 1);

      // boundary vectors
      do_reset();
      foreach (t2[j]) begin
         for (int r = 0; r < t2[j].reps; r++) send(t2[j].f, 0);
         check_disp("bound", t2[j].l, t2[j].n, t2[j].v);
      end

      // interrupted run
      do_reset();
      send(440, 0);
      send(440, 0);
      send(330, 0);
      send(440, 0);
      send(440, 0);
      check_disp("interrupt_blank", 8'h20, 8'h20, 0);
      send(440, 0);
      check_disp("interrupt_a4", 8'h41, 8'h34, 1);

      // held valid, busy periods ignore the source
      do_reset();
      send(440, 1);
      send(20, 1);
      send(440, 1);

      // reset in the middle of a scan
      do_reset();
      for (int i = 0; i < 3; i++) send(440, 0);
      @(negedge clk);
      freq  = 16'd440;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_disp("midreset", 8'h20, 8'h20, 0);
      check("midreset_ready", int'(r0), 1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      send(440, 0);
      send(440, 0);
      check_disp("post_reset_blank", 8'h20, 8'h20, 0);
      send(440, 0);
      check_disp("post_reset_a4", 8'h41, 8'h34, 1);

      // random samples on default instance
      do_reset();
      for (int g = 0; g < 40; g++) begin
         int f, reps;
         f    = $urandom_range(40, 1100);
         reps = $urandom_range(1, 4);
         for (int r = 0; r < reps; r++) send(f, 1'($urandom_range(0, 1)));
      end

      // narrow instance
      sel = 1'b1;
      do_reset();
      foreach (t6[j]) begin
         send(t6[j].f, 0);
         check_disp("narrow", t6[j].l, t6[j].n, t6[j].v);
      end
      for (int g = 0; g < 40; g++) begin
         int f, reps;
         f    = $urandom_range(100, 600);
         reps = $urandom_range(1, 2);
         for (int r = 0; r < reps; r++) send(f, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
